num_display_ctrl: RTL and testbench
===================================

# num_display_ctrl

Sequential controller that converts a binary value into three decimal digits (units, tens, hundreds) by repeated subtraction, with a start/busy/done handshake. It also time-multiplexes those digits onto a three-digit common-anode seven-segment display. It sits between the processor's result register and the board display and replaces the free-running combinational divide/modulo digit split with a bounded-latency, divider-free datapath.

## Interface
- `WIDTH`, 32: width of the input value.
- `SCAN_DIV`, 50000: clock cycles each digit stays lit, ≥ 2.
- `clk` in 1: system clock. All state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: request a conversion of `num`. Sampled only in IDLE.
- `num` in WIDTH: value to convert. Sampled on the edge that accepts `start`.
- `busy` out 1: high while a conversion is in progress.
- `done` out 1: one-cycle pulse when the digit outputs update.
- `overflow` out 1: last accepted `num` was > 999. Held until the next accepted start.
- `unidad` out 4: units digit, BCD.
- `decimal` out 4: tens digit, BCD.
- `centena` out 4: hundreds digit, BCD.
- `an` out 3: digit enables, active-low, one-hot-zero. `an[0]` selects units, `an[2]` selects hundreds.
- `seg` out 7: segments {g,f,e,d,c,b,a}, active-low.

## Operation
- **FSM states:** IDLE, HUND, TENS, DONE.
- **Working registers:** `rem` (10 bits), `c` (4 bits), `d` (4 bits).
- **IDLE, with `start`=1:**
  - `rem` ← (`num` > 999 ? 999 : `num`); `c`, `d` ← 0.
  - Latch the overflow flag into a pending register.
  - Go to HUND.
- **IDLE, with `start`=0:** stay in IDLE.
- **HUND:** if `rem` ≥ 100, then `rem` −= 100 and `c`++. Otherwise go to TENS.
- **TENS:** if `rem` ≥ 10, then `rem` −= 10 and `d`++. Otherwise go to DONE.
- **DONE:**
  - `centena` ← `c`, `decimal` ← `d`, `unidad` ← `rem[3:0]`, `overflow` ← pending flag.
  - Assert `done` for the next cycle; go to IDLE.
- **Busy and done:**
  - `busy` = (state ≠ IDLE).
  - `start` while busy is ignored; it is neither queued nor allowed to corrupt `num` capture.
  - `start` held high in the cycle `done` is asserted is accepted, because the FSM is already in IDLE.
- **Arithmetic:** only compare and subtract on 10 bits. No divider or modulo operator. `c` and `d` never exceed 9.
- **Scanner:**
  - Free-running counter from 0 to `SCAN_DIV`−1 and a 2-bit index cycling 0→1→2→0.
  - The index advances on the edge where the counter wraps. Index 3 is never reached.
- **Scanner outputs:**
  - `an` = ~(1 << idx).
  - `seg` = decode of the selected digit: idx 0 shows `unidad`, 1 shows `decimal`, 2 shows `centena`.
  - The scanner displays the registered outputs, so it never shows an intermediate conversion value.
- **Decode table:** 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0011000. Values 10–15 give 1111111 (blank).

## Timing
- **Reset values:**
  - FSM in IDLE; `busy`=0, `done`=0, `overflow`=0.
  - `unidad`=`decimal`=`centena`=0.
  - Scan counter=0, idx=0, so `an`=110 and `seg`=1000000.
- **Latency:** the edge accepting `start` is edge 0. `done` is high in the cycle after edge c+d+3, where c and d are the resulting hundreds and tens digits.
  - Minimum latency is 3 cycles.
  - Maximum latency is 21 cycles (999 or overflow).
- **Output update:** digit and `overflow` outputs change on the same edge that raises `done`. They are otherwise stable.
- **Reset mid-conversion:** aborts immediately; outputs return to reset values and no `done` pulse is produced.
- **Scanner timing:** each digit is lit for exactly `SCAN_DIV` cycles. The scanner runs independently of the conversion FSM.

## Test plan
- **Reset:** assert `rst` asynchronously mid-cycle.
  - Expect all outputs at reset values immediately, with `an`=110 and `seg`=1000000.
- **Zero:** `num`=0 with `start` pulse.
  - Expect `done` 3 cycles later, digits 0/0/0, `overflow`=0.
  - Expect `busy` high for exactly 3 cycles.
- **987:** `num`=987.
  - Expect `done` 20 cycles after acceptance; `centena`=9, `decimal`=8, `unidad`=7.
- **Overflow:** `num`=1000, then `num`=32'hFFFFFFFF.
  - Each gives 9/9/9 with `overflow`=1 after 21 cycles.
  - A following `num`=5 gives 0/0/5 with `overflow`=0 after 3 cycles.
- **Handshake:** start `num`=250; pulse `start` with `num`=7 while busy; hold `start` high with `num`=42 during the `done` cycle.
  - Expect the busy-time start ignored (result 2/5/0), then 0/4/2.
- **Scan, with `SCAN_DIV`=4 and digits 1/2/3:**
  - Expect `an` sequence 110, 101, 011, each held 4 cycles.
  - Expect `seg` = 0110000, 0100100, 1111001 respectively.
- **Reset mid-conversion:** assert `rst` 5 cycles after accepting 999.
  - Expect no `done` pulse and digits 0/0/0.
  - A new conversion afterwards completes normally.

Source files
------------

// File: rtl/num_display_ctrl.sv
// Binary-to-BCD (3 digits) converter by repeated subtraction with start/busy/done handshake,
// plus a free-running multiplexer driving a 3-digit common-anode seven-segment display.
module num_display_ctrl #(
   parameter int WIDTH    = 32,
   parameter int SCAN_DIV = 50000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] num,
   output logic             busy,
   output logic             done,
   output logic             overflow,
   output logic [3:0]       unidad,
   output logic [3:0]       decimal,
   output logic [3:0]       centena,
   output logic [2:0]       an,
   output logic [6:0]       seg
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] HUND = 2'd1;
   localparam logic [1:0] TENS = 2'd2;
   localparam logic [1:0] DONE = 2'd3;

   localparam int CW = $clog2(SCAN_DIV);

   logic [1:0]    state;
   logic [9:0]    rem;
   logic [3:0]    c;
   logic [3:0]    d;
   logic          ovf_pend;
   logic [CW-1:0] cnt;
   logic [1:0]    idx;
   logic [3:0]    digit;

   assign busy = (state != IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         rem      <= 10'd0;
         c        <= 4'd0;
         d        <= 4'd0;
         ovf_pend <= 1'b0;
         done     <= 1'b0;
         overflow <= 1'b0;
         unidad   <= 4'd0;
         decimal  <= 4'd0;
         centena  <= 4'd0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  // Values above 999 saturate so the digit loop stays bounded.
                  rem      <= (num > WIDTH'(999)) ? 10'd999 : num[9:0];
                  c        <= 4'd0;
                  d        <= 4'd0;
                  ovf_pend <= (num > WIDTH'(999));
                  state    <= HUND;
               end
            end
            HUND: begin
               if (rem >= 10'd100) begin
                  rem <= rem - 10'd100;
                  c   <= c + 4'd1;
               end else begin
                  state <= TENS;
               end
            end
            TENS: begin
               if (rem >= 10'd10) begin
                  rem <= rem - 10'd10;
                  d   <= d + 4'd1;
               end else begin
                  state <= DONE;
               end
            end
            DONE: begin
               centena  <= c;
               decimal  <= d;
               unidad   <= rem[3:0];
               overflow <= ovf_pend;
               done     <= 1'b1;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
         idx <= 2'd0;
      end else if (cnt == CW'(SCAN_DIV - 1)) begin
         cnt <= '0;
         idx <= (idx == 2'd2) ? 2'd0 : idx + 2'd1;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

   // Only the registered digits are shown, never the in-flight working registers.
   always_comb begin
      an    = 3'b111;
      digit = 4'hF;
      case (idx)
         2'd0: begin an = 3'b110; digit = unidad;  end
         2'd1: begin an = 3'b101; digit = decimal; end
         2'd2: begin an = 3'b011; digit = centena; end
         default: begin an = 3'b111; digit = 4'hF; end
      endcase
   end

   always_comb begin
      seg = 7'b1111111;
      case (digit)
         4'd0: seg = 7'b1000000;
         4'd1: seg = 7'b1111001;
         4'd2: seg = 7'b0100100;
         4'd3: seg = 7'b0110000;
         4'd4: seg = 7'b0011001;
         4'd5: seg = 7'b0010010;
         4'd6: seg = 7'b0000010;
         4'd7: seg = 7'b1111000;
         4'd8: seg = 7'b0000000;
         4'd9: seg = 7'b0011000;
         default: seg = 7'b1111111;
      endcase
   end

endmodule

// File: tb/tb_num_display_ctrl.sv
// Randomized self-checking bench: digits and latency from decimal arithmetic, scan from elapsed cycles.
module tb_num_display_ctrl;

   localparam int SD = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic [31:0] num = 32'd0;
   logic        busy, done, overflow;
   logic [3:0]  unidad, decimal, centena;
   logic [2:0]  an;
   logic [6:0]  seg;

   int checks = 0;
   int failures = 0;
   int scan_t;

   logic [3:0] m_u = 4'd0, m_d = 4'd0, m_c = 4'd0;
   logic       m_ovf = 1'b0;
   logic [6:0] dec_tab [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                 7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0011000};

   num_display_ctrl #(.WIDTH(32), .SCAN_DIV(SD)) dut (
      .clk(clk), .rst(rst), .start(start), .num(num),
      .busy(busy), .done(done), .overflow(overflow),
      .unidad(unidad), .decimal(decimal), .centena(centena),
      .an(an), .seg(seg)
   );

   always #5 clk = ~clk;

   // Cycles elapsed since reset release; the scan position follows from this alone.
   always @(posedge clk or posedge rst) begin
      if (rst) scan_t <= 0;
      else     scan_t <= scan_t + 1;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_all(input logic eb, input logic ed);
      int         i;
      logic [3:0] dg;
      logic [2:0] ea;
      chk("busy", 32'(busy), 32'(eb));
      chk("done", 32'(done), 32'(ed));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("unidad", 32'(unidad), 32'(m_u));
      chk("decimal", 32'(decimal), 32'(m_d));
      chk("centena", 32'(centena), 32'(m_c));
      i  = (scan_t / SD) % 3;
      dg = (i == 0) ? m_u : (i == 1) ? m_d : m_c;
      ea = 3'b111;
      ea[i] = 1'b0;
      chk("an", 32'(an), 32'(ea));
      chk("seg", 32'(seg), 32'(dec_tab[dg]));
   endtask

   task automatic idle(input int k);
      for (int i = 0; i < k; i++) begin
         @(negedge clk);
         check_all(1'b0, 1'b0);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      m_u = 4'd0; m_d = 4'd0; m_c = 4'd0; m_ovf = 1'b0;
      check_all(1'b0, 1'b0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Starts a conversion and checks every cycle until the done pulse; returns in the done cycle.
   task automatic conv(input logic [31:0] v, input bit inject);
      int vv, c, d, lat;
      vv  = (v > 32'd999) ? 999 : int'(v);
      c   = vv / 100;
      d   = (vv / 10) % 10;
      lat = c + d + 3;
      start = 1'b1;
      num   = v;
      @(posedge clk);
      #1;
      start = 1'b0;
      num   = $urandom;
      for (int n = 0; n <= lat; n++) begin
         @(negedge clk);
         if (inject && n == 1) begin start = 1'b1; num = 32'd7; end
         if (inject && n == 2) begin start = 1'b0; num = $urandom; end
         if (n == lat) begin
            m_c   = 4'(c);
            m_d   = 4'(d);
            m_u   = 4'(vv % 10);
            m_ovf = (v > 32'd999);
         end
         check_all(n < lat, n == lat);
      end
   endtask

   initial begin
      logic [31:0] v;
      #13;
      do_reset();
      idle(3);

      conv(32'd0, 1'b0);
      idle(2);
      conv(32'd987, 1'b0);
      idle(1);
      conv(32'd1000, 1'b0);
      conv(32'hFFFFFFFF, 1'b0);
      conv(32'd5, 1'b0);
      idle(2);

      // Busy-time start is ignored; start held during done chains into the next conversion.
      conv(32'd250, 1'b1);
      conv(32'd42, 1'b0);
      idle(2);

      conv(32'd123, 1'b0);
      idle(14);

      start = 1'b1;
      num   = 32'd999;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (5) @(negedge clk);
      chk("busy_mid", 32'(busy), 32'd1);
      #2;
      do_reset();
      idle(25);
      conv(32'd412, 1'b0);
      idle(1);

      repeat (20) begin
         v = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 1100));
         conv(v, 1'($urandom_range(0, 1)));
         idle($urandom_range(0, 3));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout t=%0t", $time);
      $fatal(1, "timeout");
   end

endmodule
